// File: rtl/abstract_cmd_sequencer.sv
// Abstract-command sequencer: validates Access Register commands, runs the register transfer
// over a req/gnt/rvalid port, optionally post-increments regno and triggers program-buffer
// execution. Owns cmdbusy and the sticky cmderr field.
module abstract_cmd_sequencer #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MaxAar          = 3,
    parameter bit          SupportPostIncr = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    input  logic [31:0]     cmd_i,
    input  logic            halted_i,
    input  logic [XLEN-1:0] arg_i,
    output logic            arg_we_o,
    output logic [XLEN-1:0] arg_o,
    output logic            reg_req_o,
    output logic            reg_we_o,
    output logic [15:0]     reg_addr_o,
    output logic [XLEN-1:0] reg_wdata_o,
    input  logic            reg_gnt_i,
    input  logic            reg_rvalid_i,
    input  logic [XLEN-1:0] reg_rdata_i,
    input  logic            reg_err_i,
    output logic            exec_req_o,
    input  logic            exec_done_i,
    input  logic            exec_exc_i,
    output logic            regno_upd_o,
    output logic [15:0]     regno_o,
    output logic            cmdbusy_o,
    output logic [2:0]      cmderr_o,
    input  logic [2:0]      cmderr_clr_i
);

    localparam logic [7:0] CmdAccessReg = 8'd0;

    localparam logic [2:0] ErrNone   = 3'd0;
    localparam logic [2:0] ErrBusy   = 3'd1;
    localparam logic [2:0] ErrNotSup = 3'd2;
    localparam logic [2:0] ErrExc    = 3'd3;
    localparam logic [2:0] ErrHalt   = 3'd4;

    typedef enum logic [1:0] {StIdle, StReq, StResp, StExec} state_e;

    // Keep only the low 2^size bytes of a register value, zero-extended.
    function automatic logic [XLEN-1:0] size_mask(input logic [XLEN-1:0] val,
                                                  input logic [2:0]      size);
        logic [XLEN-1:0] mask;
        mask = '1;
        case (size)
            3'd0:    mask = XLEN'(8'hFF);
            3'd1:    mask = XLEN'(16'hFFFF);
            3'd2:    mask = XLEN'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
        return val & mask;
    endfunction

    state_e          r_state;
    state_e          w_state_next;
    logic [2:0]      r_cmderr;
    logic [2:0]      w_cmderr_next;
    logic [2:0]      w_set_err;
    logic            w_capture;
    logic            w_arg_we;
    logic            w_regno_upd;
    logic            w_exec_entry;

    logic [2:0]      r_size;
    logic            r_postincr;
    logic            r_postexec;
    logic            r_write;
    logic [15:0]     r_regno;
    logic [XLEN-1:0] r_wdata;
    logic            r_arg_we;
    logic [XLEN-1:0] r_arg;
    logic            r_regno_upd;
    logic [15:0]     r_regno_out;
    logic            r_exec_req;

    logic [7:0]      w_cmdtype;
    logic [2:0]      w_aarsize;
    logic            w_postincr;
    logic            w_postexec;
    logic            w_transfer;
    logic            w_write;
    logic [15:0]     w_regno;
    logic            w_unused_cmd;

    assign w_cmdtype    = cmd_i[31:24];
    assign w_aarsize    = cmd_i[22:20];
    assign w_postincr   = cmd_i[19];
    assign w_postexec   = cmd_i[18];
    assign w_transfer   = cmd_i[17];
    assign w_write      = cmd_i[16];
    assign w_regno      = cmd_i[15:0];
    assign w_unused_cmd = cmd_i[23];

    // Next-state decode: command validation, transfer sequencing and error reporting.
    always_comb begin
        w_state_next = r_state;
        w_set_err    = ErrNone;
        w_capture    = 1'b0;
        w_arg_we     = 1'b0;
        w_regno_upd  = 1'b0;
        w_exec_entry = 1'b0;

        // A command arriving while one runs is flagged but does not disturb it.
        if (cmd_valid_i && (r_state != StIdle) && (r_cmderr == ErrNone)) begin
            w_set_err = ErrBusy;
        end

        unique case (r_state)
            StIdle: begin
                if (cmd_valid_i && (r_cmderr == ErrNone)) begin
                    if (w_cmdtype != CmdAccessReg) begin
                        w_set_err = ErrNotSup;
                    end else if (32'(w_aarsize) >= MaxAar) begin
                        w_set_err = ErrNotSup;
                    end else if (w_postincr && (SupportPostIncr == 1'b0)) begin
                        w_set_err = ErrNotSup;
                    end else if (w_transfer && (w_regno[15:14] != 2'b00)) begin
                        w_set_err = ErrNotSup;
                    end else if (!halted_i) begin
                        w_set_err = ErrHalt;
                    end else begin
                        w_capture = 1'b1;
                        if (w_transfer) begin
                            w_state_next = StReq;
                        end else if (w_postexec) begin
                            w_state_next = StExec;
                            w_exec_entry = 1'b1;
                        end
                    end
                end
            end
            StReq: begin
                if (reg_gnt_i) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (reg_rvalid_i) begin
                    if (reg_err_i) begin
                        w_set_err    = ErrExc;
                        w_state_next = StIdle;
                    end else begin
                        w_arg_we    = !r_write;
                        w_regno_upd = r_postincr;
                        if (r_postexec) begin
                            w_state_next = StExec;
                            w_exec_entry = 1'b1;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end
                end
            end
            StExec: begin
                // Done is ignored during the request pulse cycle itself.
                if (!r_exec_req && exec_done_i) begin
                    if (exec_exc_i) begin
                        w_set_err = ErrExc;
                    end
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase

        // A freshly raised error takes precedence over a simultaneous W1C clear.
        w_cmderr_next = (w_set_err != ErrNone) ? w_set_err : (r_cmderr & ~cmderr_clr_i);
    end

    // State, sticky error and single-cycle pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_cmderr    <= ErrNone;
            r_arg_we    <= 1'b0;
            r_regno_upd <= 1'b0;
            r_exec_req  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmderr    <= w_cmderr_next;
            r_arg_we    <= w_arg_we;
            r_regno_upd <= w_regno_upd;
            r_exec_req  <= w_exec_entry;
        end
    end

    // Capture the command fields and write data so the request stays stable while pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_size     <= 3'd0;
            r_postincr <= 1'b0;
            r_postexec <= 1'b0;
            r_write    <= 1'b0;
            r_regno    <= 16'd0;
            r_wdata    <= '0;
        end else if (w_capture) begin
            r_size     <= w_aarsize;
            r_postincr <= w_postincr;
            r_postexec <= w_postexec;
            r_write    <= w_write;
            r_regno    <= w_regno;
            r_wdata    <= size_mask(arg_i, w_aarsize);
        end
    end

    // Response data: read-back value and the incremented regno (wraps at 16 bits).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arg       <= '0;
            r_regno_out <= 16'd0;
        end else begin
            if (w_arg_we) begin
                r_arg <= size_mask(reg_rdata_i, r_size);
            end
            if (w_regno_upd) begin
                r_regno_out <= r_regno + 16'd1;
            end
        end
    end

    assign reg_req_o   = (r_state == StReq);
    assign reg_we_o    = r_write;
    assign reg_addr_o  = r_regno;
    assign reg_wdata_o = r_wdata;
    assign arg_we_o    = r_arg_we;
    assign arg_o       = r_arg;
    assign regno_upd_o = r_regno_upd;
    assign regno_o     = r_regno_out;
    assign exec_req_o  = r_exec_req;
    assign cmdbusy_o   = (r_state != StIdle);
    assign cmderr_o    = r_cmderr;

endmodule

// File: tb/tb_abstract_cmd_sequencer.sv
// Self-checking bench for abstract_cmd_sequencer: error-code vector table, hand-written
// multi-cycle sequences and randomized commands against a transaction-level model.
module tb_abstract_cmd_sequencer;

    localparam int XLEN       = 32;
    localparam int MAX_AAR    = 3;
    localparam bit SUPPORT_PI = 1'b1;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            cmd_valid_i = 1'b0;
    logic [31:0]     cmd_i = '0;
    logic            halted_i = 1'b0;
    logic [XLEN-1:0] arg_i = '0;
    logic            arg_we_o;
    logic [XLEN-1:0] arg_o;
    logic            reg_req_o;
    logic            reg_we_o;
    logic [15:0]     reg_addr_o;
    logic [XLEN-1:0] reg_wdata_o;
    logic            reg_gnt_i = 1'b0;
    logic            reg_rvalid_i = 1'b0;
    logic [XLEN-1:0] reg_rdata_i = '0;
    logic            reg_err_i = 1'b0;
    logic            exec_req_o;
    logic            exec_done_i = 1'b0;
    logic            exec_exc_i = 1'b0;
    logic            regno_upd_o;
    logic [15:0]     regno_o;
    logic            cmdbusy_o;
    logic [2:0]      cmderr_o;
    logic [2:0]      cmderr_clr_i = '0;

    abstract_cmd_sequencer #(
        .XLEN            (XLEN),
        .MaxAar          (MAX_AAR),
        .SupportPostIncr (SUPPORT_PI)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_i        (cmd_i),
        .halted_i     (halted_i),
        .arg_i        (arg_i),
        .arg_we_o     (arg_we_o),
        .arg_o        (arg_o),
        .reg_req_o    (reg_req_o),
        .reg_we_o     (reg_we_o),
        .reg_addr_o   (reg_addr_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_gnt_i    (reg_gnt_i),
        .reg_rvalid_i (reg_rvalid_i),
        .reg_rdata_i  (reg_rdata_i),
        .reg_err_i    (reg_err_i),
        .exec_req_o   (exec_req_o),
        .exec_done_i  (exec_done_i),
        .exec_exc_i   (exec_exc_i),
        .regno_upd_o  (regno_upd_o),
        .regno_o      (regno_o),
        .cmdbusy_o    (cmdbusy_o),
        .cmderr_o     (cmderr_o),
        .cmderr_clr_i (cmderr_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int m_err = 0;  // model of the sticky cmderr field

    typedef struct {
        logic [31:0] cmd;
        logic        halted;
        logic [2:0]  exp_err;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    function automatic logic [31:0] mk_cmd(input logic [7:0] ctype, input logic [2:0] size,
                                           input logic pi, input logic pe, input logic tr,
                                           input logic wr, input logic [15:0] regno);
        return {ctype, 1'b0, size, pi, pe, tr, wr, regno};
    endfunction

    // Expected cmderr for a command presented in idle with no error pending.
    function automatic int exp_err(input logic [31:0] c, input logic h);
        if (c[31:24] != 8'd0) return 2;
        if (int'(c[22:20]) >= MAX_AAR) return 2;
        if (c[19] && !SUPPORT_PI) return 2;
        if (c[17] && (c[15:14] != 2'b00)) return 2;
        if (!h) return 4;
        return 0;
    endfunction

    function automatic longint unsigned mask_to_size(input longint unsigned v, input int sz);
        longint unsigned nbits;
        nbits = 64'd8 << sz;
        if (nbits >= 64'(XLEN)) return v & 64'hFFFF_FFFF;
        return v % (64'd1 << nbits);
    endfunction

    task automatic clear_err();
        cmderr_clr_i = 3'b111;
        tick();
        cmderr_clr_i = 3'b000;
        m_err = 0;
        check("cmderr_clear", cmderr_o, 0);
    endtask

    // Run one command end to end, acting as the hart and checking each observable step.
    task automatic run_cmd(input logic [31:0] cmd, input logic halted, input logic [31:0] arg,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input logic rerr, input int ex_dly, input logic exc);
        int          e;
        logic        tr, pe, wr, pi;
        int          sz;
        logic [15:0] regno;
        e     = exp_err(cmd, halted);
        pi    = cmd[19];
        pe    = cmd[18];
        tr    = cmd[17];
        wr    = cmd[16];
        sz    = int'(cmd[22:20]);
        regno = cmd[15:0];

        cmd_valid_i = 1'b1;
        cmd_i       = cmd;
        halted_i    = halted;
        arg_i       = arg;
        tick();
        cmd_valid_i = 1'b0;
        arg_i       = $urandom;

        if (e != 0) begin
            m_err = e;
            check("err_code", cmderr_o, 64'(e));
            check("err_busy", cmdbusy_o, 0);
            check("err_noreq", reg_req_o, 0);
            return;
        end
        if (!tr && !pe) begin
            check("noop_busy", cmdbusy_o, 0);
            check("noop_err", cmderr_o, 0);
            return;
        end
        check("busy_on_accept", cmdbusy_o, 1);

        if (tr) begin
            check("req", reg_req_o, 1);
            check("req_addr", reg_addr_o, 64'(regno));
            check("req_we", reg_we_o, 64'(wr));
            check("req_wdata", reg_wdata_o, mask_to_size(64'(arg), sz));
            for (int i = 0; i < gnt_dly; i++) begin
                tick();
                check("req_hold", reg_req_o, 1);
                check("req_addr_hold", reg_addr_o, 64'(regno));
            end
            reg_gnt_i = 1'b1;
            tick();
            reg_gnt_i = 1'b0;
            check("req_drop", reg_req_o, 0);
            check("busy_resp", cmdbusy_o, 1);
            for (int i = 0; i < rv_dly; i++) begin
                tick();
                check("no_early_we", arg_we_o, 0);
            end
            reg_rvalid_i = 1'b1;
            reg_rdata_i  = rdata;
            reg_err_i    = rerr;
            tick();
            reg_rvalid_i = 1'b0;
            reg_err_i    = 1'b0;
            reg_rdata_i  = $urandom;
            if (rerr) begin
                m_err = 3;
                check("rerr_no_we", arg_we_o, 0);
                check("rerr_no_upd", regno_upd_o, 0);
                check("rerr_no_exec", exec_req_o, 0);
                check("rerr_busy", cmdbusy_o, 0);
                check("rerr_code", cmderr_o, 3);
                return;
            end
            check("arg_we", arg_we_o, 64'(!wr));
            if (!wr) check("arg_data", arg_o, mask_to_size(64'(rdata), sz));
            check("regno_upd", regno_upd_o, 64'(pi));
            if (pi) check("regno_val", regno_o, 64'((int'(regno) + 1) % 65536));
            if (!pe) begin
                check("done_busy", cmdbusy_o, 0);
                check("done_err", cmderr_o, 64'(m_err));
                return;
            end
        end

        check("exec_req", exec_req_o, 1);
        check("exec_busy", cmdbusy_o, 1);
        exec_done_i = (ex_dly == 0);
        exec_exc_i  = exc;
        tick();
        check("exec_single_pulse", exec_req_o, 0);
        check("exec_wait", cmdbusy_o, 1);
        if (ex_dly > 0) begin
            exec_done_i = 1'b0;
            for (int i = 1; i < ex_dly; i++) tick();
            exec_done_i = 1'b1;
        end
        tick();
        exec_done_i = 1'b0;
        exec_exc_i  = 1'b0;
        if (exc) m_err = 3;
        check("exec_done_busy", cmdbusy_o, 0);
        check("exec_done_err", cmderr_o, 64'(m_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mk_cmd(8'h01, 3'd2, 0, 0, 1, 0, 16'h1000), 1'b1, 3'd2, 1'b0};
        vecs[1] = '{mk_cmd(8'h00, 3'd3, 0, 0, 1, 1, 16'h1000), 1'b1, 3'd2, 1'b0};
        vecs[2] = '{mk_cmd(8'h00, 3'd4, 0, 0, 0, 0, 16'h0000), 1'b1, 3'd2, 1'b0};
        vecs[3] = '{mk_cmd(8'h00, 3'd2, 0, 0, 1, 0, 16'h4000), 1'b1, 3'd2, 1'b0};
        vecs[4] = '{mk_cmd(8'h00, 3'd2, 0, 0, 0, 0, 16'hC000), 1'b1, 3'd0, 1'b0};
        vecs[5] = '{mk_cmd(8'h00, 3'd2, 0, 0, 1, 0, 16'h1000), 1'b0, 3'd4, 1'b0};
        vecs[6] = '{mk_cmd(8'h02, 3'd2, 0, 0, 1, 0, 16'h1000), 1'b0, 3'd2, 1'b0};
        vecs[7] = '{mk_cmd(8'h00, 3'd2, 1, 0, 0, 0, 16'h0005), 1'b1, 3'd0, 1'b0};

        // Reset values
        repeat (2) tick();
        check("rst_busy", cmdbusy_o, 0);
        check("rst_err", cmderr_o, 0);
        check("rst_req", reg_req_o, 0);
        check("rst_we", reg_we_o, 0);
        check("rst_addr", reg_addr_o, 0);
        check("rst_wdata", reg_wdata_o, 0);
        check("rst_arg_we", arg_we_o, 0);
        check("rst_arg", arg_o, 0);
        check("rst_exec", exec_req_o, 0);
        check("rst_upd", regno_upd_o, 0);
        check("rst_regno", regno_o, 0);
        rst_ni = 1'b1;
        tick();

        // Validation vectors
        for (int v = 0; v < 8; v++) begin
            if (m_err != 0) clear_err();
            cmd_valid_i = 1'b1;
            cmd_i       = vecs[v].cmd;
            halted_i    = vecs[v].halted;
            tick();
            cmd_valid_i = 1'b0;
            check($sformatf("vec%0d_err", v), cmderr_o, 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_busy", v), cmdbusy_o, 64'(vecs[v].exp_busy));
            check($sformatf("vec%0d_req", v), reg_req_o, 0);
            check($sformatf("vec%0d_upd", v), regno_upd_o, 0);
            m_err = int'(vecs[v].exp_err);
        end
        if (m_err != 0) clear_err();

        // Read of 0x1008, 32-bit, immediate grant and response
        run_cmd(mk_cmd(8'h00, 3'd2, 0, 0, 1, 0, 16'h1008), 1'b1, 32'h0,
                0, 0, 32'hDEAD_BEEF, 1'b0, 1, 1'b0);

        // 64-bit access unsupported at XLEN=32, then W1C clear
        run_cmd(mk_cmd(8'h00, 3'd3, 0, 0, 1, 1, 16'h1001), 1'b1, 32'h1234_5678,
                0, 0, 32'h0, 1'b0, 1, 1'b0);
        clear_err();

        // Read 0xFFFF with postincrement wrap, postexec raising an exception
        run_cmd(mk_cmd(8'h00, 3'd2, 1, 1, 1, 0, 16'hFFFF), 1'b1, 32'h0,
                1, 1, 32'h0BAD_F00D, 1'b0, 2, 1'b1);
        clear_err();

        // Postexec-only, done asserted during the request pulse and held
        run_cmd(mk_cmd(8'h00, 3'd2, 0, 1, 0, 0, 16'h0000), 1'b1, 32'h0,
                0, 0, 32'h0, 1'b0, 0, 1'b0);

        // Command during RESP: Busy set (wins over a same-cycle clear), first command completes
        cmd_valid_i = 1'b1;
        cmd_i       = mk_cmd(8'h00, 3'd1, 0, 0, 1, 0, 16'h0300);
        halted_i    = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        reg_gnt_i   = 1'b1;
        tick();
        reg_gnt_i    = 1'b0;
        cmd_valid_i  = 1'b1;
        cmd_i        = mk_cmd(8'h00, 3'd2, 0, 1, 0, 0, 16'h0000);
        cmderr_clr_i = 3'b111;
        tick();
        cmd_valid_i  = 1'b0;
        cmderr_clr_i = 3'b000;
        check("busy_err_set", cmderr_o, 1);
        check("busy_err_running", cmdbusy_o, 1);
        reg_rvalid_i = 1'b1;
        reg_rdata_i  = 32'h1234_5678;
        tick();
        reg_rvalid_i = 1'b0;
        check("busy_err_wb", arg_we_o, 1);
        check("busy_err_wb_data", arg_o, 64'h5678);
        check("busy_err_idle", cmdbusy_o, 0);
        check("busy_err_sticky", cmderr_o, 1);
        m_err = 1;
        clear_err();

        // Not halted, then a further command is ignored while cmderr is set
        run_cmd(mk_cmd(8'h00, 3'd2, 0, 0, 1, 0, 16'h1000), 1'b0, 32'h0,
                0, 0, 32'h0, 1'b0, 1, 1'b0);
        cmd_valid_i = 1'b1;
        cmd_i       = mk_cmd(8'h00, 3'd2, 0, 0, 1, 0, 16'h1000);
        halted_i    = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        check("ignored_busy", cmdbusy_o, 0);
        check("ignored_req", reg_req_o, 0);
        check("ignored_err", cmderr_o, 4);
        tick();
        check("ignored_busy2", cmdbusy_o, 0);
        clear_err();

        // Reset while a request is pending
        cmd_valid_i = 1'b1;
        cmd_i       = mk_cmd(8'h00, 3'd2, 0, 1, 1, 1, 16'h0042);
        arg_i       = 32'hCAFE_0001;
        tick();
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        check("pre_rst_req", reg_req_o, 1);
        check("pre_rst_err", cmderr_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_req", reg_req_o, 0);
        check("arst_busy", cmdbusy_o, 0);
        check("arst_err", cmderr_o, 0);
        check("arst_addr", reg_addr_o, 0);
        check("arst_we", reg_we_o, 0);
        check("arst_exec", exec_req_o, 0);
        m_err = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_busy", cmdbusy_o, 0);
        run_cmd(mk_cmd(8'h00, 3'd0, 0, 0, 1, 0, 16'h0007), 1'b1, 32'h0,
                0, 0, 32'h0000_00A5, 1'b0, 1, 1'b0);

        // Randomized commands against the transaction model
        for (int it = 0; it < 150; it++) begin
            logic [7:0]  ctype;
            logic [2:0]  size;
            logic [15:0] regno;
            if (m_err != 0) clear_err();
            ctype = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            size  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2));
            regno = 16'($urandom);
            if ($urandom_range(0, 3) != 0) regno[15:14] = 2'b00;
            run_cmd(mk_cmd(ctype, size, 1'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), regno),
                    ($urandom_range(0, 9) != 0), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/abstract_cmd_sequencer.md
# abstract_cmd_sequencer

Sequential successor to the combinational abstract-command decoder in the Debug Module. It accepts an Access Register command and validates it against parametrised size and feature limits. It then runs the register transfer over a request/grant/response port to the halted hart, optionally post-increments `regno`, and optionally triggers program-buffer execution. It owns `cmdbusy` and the sticky `cmderr` field reported in `abstractcs`.

## Interface
- `XLEN`, default 32: hart register width, 32 or 64; sets the width of the arg and register data paths.
- `MaxAar`, default 3: smallest unsupported `aarsize`; use 4 when XLEN=64.
- `SupportPostIncr`, default 1: when 0, `aarpostincrement`=1 is NotSupported.
- `clk_i  in  1`: clock.
- `rst_ni  in  1`: asynchronous active-low reset.
- `cmd_valid_i  in  1`: one-cycle pulse when the debugger writes `command`.
- `cmd_i  in  32`: `DM::command_t`; `cmdtype[31:24]`, `control[23:0]`.
- `halted_i  in  1`: selected hart is halted.
- `arg_i  in  XLEN`: current data0(/data1) value.
- `arg_we_o  out  1`, `arg_o  out  XLEN`: write-back of read data into data0(/data1).
- `reg_req_o  out  1`, `reg_we_o  out  1`, `reg_addr_o  out  16`, `reg_wdata_o  out  XLEN`: register access request to the hart.
- `reg_gnt_i  in  1`, `reg_rvalid_i  in  1`, `reg_rdata_i  in  XLEN`, `reg_err_i  in  1`: grant, then response.
- `exec_req_o  out  1`, `exec_done_i  in  1`, `exec_exc_i  in  1`: program-buffer execution handshake.
- `regno_upd_o  out  1`, `regno_o  out  16`: post-incremented `regno` to write back into `command`.
- `cmdbusy_o  out  1`: command in progress.
- `cmderr_o  out  3`: `DM::cmderr_e`, sticky.
- `cmderr_clr_i  in  3`: W1C bits from the `abstractcs` write.

## Operation
- States: IDLE, REQ, RESP, EXEC.
- Accept rule: a command is accepted only in IDLE, with `cmd_valid_i`=1 and `cmderr_o`=0.
- When `cmderr_o`≠0, a `cmd_valid_i` pulse is ignored with no state change.
- When `cmd_valid_i` arrives outside IDLE, `cmderr_o` is set to 1 (Busy) if it is 0; the running command continues.
- Checks on accept, applied in this order:
  - `cmdtype`≠AccessRegister → 2.
  - `aarsize`≥MaxAar → 2.
  - `aarpostincrement`=1 with SupportPostIncr=0 → 2.
  - `transfer`=1 and `regno[15:14]`≠0 → 2.
  - `halted_i`=0 → 4 (HaltResume).
  - On any error, the FSM stays in IDLE.
- After a successful accept, capture the control fields and go to:
  - REQ if `transfer`=1;
  - EXEC if only `postexec`=1;
  - IDLE (no-op) otherwise.
- REQ: hold `reg_req_o`=1 with stable addr, we and wdata until `reg_gnt_i`, then go to RESP.
- `reg_wdata_o` = `arg_i` masked to 2^`aarsize` bytes, zero-extended.
- RESP: wait for `reg_rvalid_i`.
  - If `reg_err_i`=1: `cmderr_o`=3 (Exception), no write-back, no increment, no exec; go to IDLE.
  - On a read: pulse `arg_we_o` with `reg_rdata_i` masked to the size, zero-extended.
  - If postincrement is set: pulse `regno_upd_o` with `regno_o`=`regno`+1, mod 2^16 (0xFFFF→0x0000).
  - Then go to EXEC if `postexec`=1, else IDLE.
- EXEC: pulse `exec_req_o` once on entry, then wait for `exec_done_i`.
  - If `exec_exc_i`=1 at done: `cmderr_o`=3.
  - Go to IDLE.
- `cmderr_o`: each bit is cleared where `cmderr_clr_i` is 1. A new error set in the same cycle wins over the clear.

## Timing
- Reset values: state IDLE; all outputs 0; `reg_addr_o`=0; `regno_o`=0; `cmderr_o`=0.
- Reset asserted mid-command aborts immediately: no pulses, busy=0.
- An accept at edge N gives `cmdbusy_o`=1 from N+1 until the edge that returns to IDLE.
- `cmdbusy_o`=1 exactly when state≠IDLE.
- `reg_req_o` is registered and first high at N+1.
- `arg_we_o` and `regno_upd_o` are single-cycle pulses in the cycle after `reg_rvalid_i`.
- `exec_req_o` is a single-cycle pulse; `exec_done_i` in that same cycle is not accepted before the next cycle.
- Minimum read+postexec latency, accept to busy low: 5 cycles, with grant and rvalid each one cycle after the request.
- Command errors are visible at N+1. The no-op command (`transfer`=0, `postexec`=0) leaves busy=0 throughout.

## Test plan
- Read of regno 0x1008 with aarsize=2, grant and rvalid immediate, rdata=0xDEADBEEF:
  - `reg_addr_o`=0x1008 and `reg_we_o`=0;
  - then `arg_we_o` pulse with 0xDEADBEEF;
  - busy drops, `cmderr_o`=0.
- Write with aarsize=3 at XLEN=32 (MaxAar=3) → `cmderr_o`=2, no request. Then write `cmderr_clr_i`=3'b111 → `cmderr_o`=0.
- Read of regno 0xFFFF with postincrement, then postexec with `exec_exc_i`=1 at done:
  - `regno_o`=0x0000 pulse;
  - `exec_req_o` pulse;
  - `cmderr_o`=3.
- `cmd_valid_i` during RESP → `cmderr_o`=1; the first command still completes with its write-back.
- Command with `halted_i`=0 → `cmderr_o`=4. A following `cmd_valid_i` with cmderr still set is ignored (busy stays 0).
- `rst_ni` pulled low while in REQ → all outputs 0 asynchronously; after release, a fresh read completes normally.
